// File: rtl/mem_write_checker.sv
// Monitors the core's data-memory write port against a loadable table of expected stores.
// It counts matched and failed stores, detects the end-of-program marker and runs a stall watchdog.
module mem_write_checker #(
   parameter int unsigned         ADDR_W       = 32,
   parameter int unsigned         DATA_W       = 32,
   parameter int unsigned         DEPTH        = 64,
   parameter int unsigned         ORDERED      = 0,
   parameter int unsigned         STOP_ON_FAIL = 1,
   parameter logic [ADDR_W-1:0]   DONE_ADR     = ADDR_W'(40),
   parameter logic [DATA_W-1:0]   DONE_DATA    = DATA_W'(30),
   parameter logic [ADDR_W-1:0]   IGN_LO       = ADDR_W'(96),
   parameter logic [ADDR_W-1:0]   IGN_HI       = ADDR_W'(99),
   parameter int unsigned         TIMEOUT      = 100000,
   parameter int unsigned         CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_adr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_full,
   input  logic              start,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              busy,
   output logic              done,
   output logic              failed,
   output logic              timed_out,
   output logic [CNT_W-1:0]  pass_count,
   output logic [CNT_W-1:0]  fail_count,
   output logic [CNT_W-1:0]  missing_count,
   output logic [ADDR_W-1:0] fail_adr,
   output logic [DATA_W-1:0] fail_data
);

   typedef enum logic [2:0] {StLoad, StRun, StDone, StFail, StTmo} state_e;

   localparam int unsigned      WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CntDepth = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
   localparam logic [WD_W-1:0]  WdLimit  = WD_W'(TIMEOUT);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  pass_q, pass_d;
   logic [CNT_W-1:0]  fail_q, fail_d;
   logic [DEPTH-1:0]  hit_q, hit_d;
   logic              failed_q, failed_d;
   logic [ADDR_W-1:0] fail_adr_q, fail_adr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [ADDR_W-1:0] tbl_adr_q  [DEPTH];
   logic [DATA_W-1:0] tbl_data_q [DEPTH];

   logic              tbl_we;
   logic [DEPTH-1:0]  entry_eq, entry_valid, hit_set;
   logic              ord_match, any_match, match, is_marker, in_ign;

   always_comb begin
      entry_eq    = '0;
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_eq[i]    = (tbl_adr_q[i] == DataAdr) && (tbl_data_q[i] == WriteData);
         entry_valid[i] = CNT_W'(i) < n_q;
      end
   end

   // Ordered mode checks only the entry at rd_ptr; any-order picks the lowest un-hit equal entry.
   always_comb begin
      ord_match = 1'b0;
      any_match = 1'b0;
      hit_set   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) == rd_ptr_q) && entry_valid[i] && entry_eq[i]) begin
            ord_match = 1'b1;
         end
         if (!any_match && entry_valid[i] && !hit_q[i] && entry_eq[i]) begin
            any_match  = 1'b1;
            hit_set[i] = 1'b1;
         end
      end
   end

   assign match     = (ORDERED != 0) ? ord_match : any_match;
   assign is_marker = (DataAdr == DONE_ADR) && (WriteData == DONE_DATA);
   assign in_ign    = (DataAdr >= IGN_LO) && (DataAdr <= IGN_HI);

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      rd_ptr_d    = rd_ptr_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      hit_d       = hit_q;
      failed_d    = failed_q;
      fail_adr_d  = fail_adr_q;
      fail_data_d = fail_data_q;
      wd_d        = wd_q;
      tbl_we      = 1'b0;
      unique case (state_q)
         StLoad: begin
            if (load_valid && (n_q != CntDepth)) begin
               tbl_we = 1'b1;
               n_d    = n_q + 1'b1;
            end
            if (start) begin
               state_d = StRun;
               wd_d    = '0;
            end
         end
         StRun: begin
            if (MemWrite) begin
               wd_d = '0;
               if (match) begin
                  pass_d = pass_q + 1'b1;
                  if (ORDERED != 0) rd_ptr_d = rd_ptr_q + 1'b1;
                  else              hit_d    = hit_q | hit_set;
               end else if (is_marker) begin
                  state_d = StDone;
               end else if (!in_ign) begin
                  if (fail_q != CntMax) fail_d = fail_q + 1'b1;
                  if (!failed_q) begin
                     fail_adr_d  = DataAdr;
                     fail_data_d = WriteData;
                  end
                  failed_d = 1'b1;
                  if (STOP_ON_FAIL != 0) state_d = StFail;
               end
            end else if (TIMEOUT != 0) begin
               wd_d = wd_q + 1'b1;
               if (wd_d == WdLimit) state_d = StTmo;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StLoad;
         n_q         <= '0;
         rd_ptr_q    <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         hit_q       <= '0;
         failed_q    <= 1'b0;
         fail_adr_q  <= '0;
         fail_data_q <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         rd_ptr_q    <= rd_ptr_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         hit_q       <= hit_d;
         failed_q    <= failed_d;
         fail_adr_q  <= fail_adr_d;
         fail_data_q <= fail_data_d;
         wd_q        <= wd_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_adr_q[i]  <= '0;
            tbl_data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (tbl_we && (CNT_W'(i) == n_q)) begin
               tbl_adr_q[i]  <= load_adr;
               tbl_data_q[i] <= load_data;
            end
         end
      end
   end

   assign load_full     = (n_q == CntDepth);
   assign busy          = (state_q == StRun);
   assign done          = (state_q == StDone);
   assign timed_out     = (state_q == StTmo);
   assign failed        = failed_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign missing_count = n_q - pass_q;
   assign fail_adr      = fail_adr_q;
   assign fail_data     = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered/stop-on-fail instance and an any-order/keep-going
// instance share stimulus and are checked against a table-level reference model.
module tb_mem_write_checker;

   localparam int DEPTH = 8;
   localparam int CW    = 4;
   localparam int TMO   = 50;
   localparam int ML = 0, MR = 1, MD = 2, MF = 3, MT = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic load_valid = 1'b0, start = 1'b0, MemWrite = 1'b0;
   logic [31:0] load_adr = '0, load_data = '0, DataAdr = '0, WriteData = '0;
   logic load_full [2], busy [2], done [2], failed [2], timed_out [2];
   logic [CW-1:0] pass_count [2], fail_count [2], missing_count [2];
   logic [31:0] fail_adr [2], fail_data [2];

   int checks = 0;
   int errors = 0;

   // Reference model; index 0 = ordered + stop on fail, index 1 = any order + keep going.
   int          ms [2], mn [2], mrp [2], mpass [2], mfail [2], mwd [2];
   bit          mfailed [2];
   bit          mhit [2][DEPTH];
   logic [31:0] mfadr [2], mfdata [2];
   logic [31:0] madr [DEPTH], mdata [DEPTH];

   always #5 clk = ~clk;

   mem_write_checker #(.DEPTH(DEPTH), .ORDERED(1), .STOP_ON_FAIL(1), .TIMEOUT(TMO)) u_ord (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_adr(load_adr),
      .load_data(load_data), .load_full(load_full[0]), .start(start), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy[0]), .done(done[0]),
      .failed(failed[0]), .timed_out(timed_out[0]), .pass_count(pass_count[0]),
      .fail_count(fail_count[0]), .missing_count(missing_count[0]), .fail_adr(fail_adr[0]),
      .fail_data(fail_data[0])
   );

   mem_write_checker #(.DEPTH(DEPTH), .ORDERED(0), .STOP_ON_FAIL(0), .TIMEOUT(TMO)) u_any (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_adr(load_adr),
      .load_data(load_data), .load_full(load_full[1]), .start(start), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy[1]), .done(done[1]),
      .failed(failed[1]), .timed_out(timed_out[1]), .pass_count(pass_count[1]),
      .fail_count(fail_count[1]), .missing_count(missing_count[1]), .fail_adr(fail_adr[1]),
      .fail_data(fail_data[1])
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ms[i] = ML; mn[i] = 0; mrp[i] = 0; mpass[i] = 0; mfail[i] = 0; mwd[i] = 0;
         mfailed[i] = 0; mfadr[i] = '0; mfdata[i] = '0;
         for (int j = 0; j < DEPTH; j++) mhit[i][j] = 0;
      end
   endtask

   task automatic model_edge(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                             input logic st, input logic mw, input logic [31:0] a,
                             input logic [31:0] d);
      bit matched;
      for (int i = 0; i < 2; i++) begin
         if (ms[i] == ML) begin
            if (lv && mn[i] < DEPTH) begin
               madr[mn[i]] = la; mdata[mn[i]] = ld; mn[i]++;
            end
            if (st) begin ms[i] = MR; mwd[i] = 0; end
         end else if (ms[i] == MR) begin
            if (mw) begin
               mwd[i] = 0;
               matched = 0;
               if (i == 0) begin
                  if (mrp[i] < mn[i] && madr[mrp[i]] == a && mdata[mrp[i]] == d) begin
                     matched = 1; mrp[i]++;
                  end
               end else begin
                  for (int j = 0; j < DEPTH; j++)
                     if (!matched && j < mn[i] && !mhit[i][j] && madr[j] == a && mdata[j] == d) begin
                        matched = 1; mhit[i][j] = 1;
                     end
               end
               if (matched) mpass[i]++;
               else if (a == 40 && d == 30) ms[i] = MD;
               else if (a >= 96 && a <= 99) ;
               else begin
                  if (mfail[i] < 15) mfail[i]++;
                  if (!mfailed[i]) begin mfadr[i] = a; mfdata[i] = d; end
                  mfailed[i] = 1;
                  if (i == 0) ms[i] = MF;
               end
            end else begin
               mwd[i]++;
               if (mwd[i] == TMO) ms[i] = MT;
            end
         end
      end
   endtask

   task automatic step(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic st, input logic mw, input logic [31:0] a,
                       input logic [31:0] d);
      load_valid = lv; load_adr = la; load_data = ld; start = st;
      MemWrite = mw; DataAdr = a; WriteData = d;
      @(posedge clk);
      model_edge(lv, la, ld, st, mw, a, d);
      #1;
      load_valid = 1'b0; start = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      step(1'b1, a, d, 1'b0, 1'b0, '0, '0);
   endtask
   task automatic go();
      step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
   endtask
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, '0, '0, 1'b0, 1'b1, a, d);
   endtask
   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #3;
      reset = 1'b1;
   endtask

   task automatic load_std();
      load(100, 25); load(104, 4096); load(108, 4184);
   endtask

   task automatic test_reset();
      logic [80:0] got;
      reset = 1'b0;
      model_reset();
      #2;
      for (int i = 0; i < 2; i++) begin
         got = {busy[i], done[i], timed_out[i], failed[i], load_full[i], pass_count[i],
                fail_count[i], missing_count[i], fail_adr[i], fail_data[i]};
         checks++;
         if (got !== '0) begin
            errors++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, got);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_ordered_pass();
      do_reset();
      load_std(); go();
      store(100, 25); store(104, 4096); store(108, 4184);
      checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL ordered_pre_marker: got done=%b busy=%b want 0 1", done[0], busy[0]);
      end
      store(40, 30);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pass_count[i], missing_count[i], done[i], failed[i], busy[i]} !== {4'd3, 4'd0, 3'b100}) begin
            errors++;
            $display("FAIL ordered_pass[%0d]: got pass=%0d miss=%0d done=%b failed=%b busy=%b want 3 0 1 0 0",
                     i, pass_count[i], missing_count[i], done[i], failed[i], busy[i]);
         end
      end
   endtask

   task automatic test_any_order();
      do_reset();
      load_std(); go();
      store(108, 4184); store(97, 32'hAA); store(100, 25); store(104, 4096); store(40, 30);
      checks++;
      if ({pass_count[1], fail_count[1], done[1]} !== {4'd3, 4'd0, 1'b1}) begin
         errors++; $display("FAIL any_order: got pass=%0d fail=%0d done=%b want 3 0 1",
                            pass_count[1], fail_count[1], done[1]);
      end
      checks++;
      if ({failed[0], done[0], pass_count[0], fail_adr[0], fail_data[0]} !== {1'b1, 1'b0, 4'd0, 32'd108, 32'd4184}) begin
         errors++; $display("FAIL ordered_out_of_order: got failed=%b done=%b pass=%0d adr=%0d data=%0d want 1 0 0 108 4184",
                            failed[0], done[0], pass_count[0], fail_adr[0], fail_data[0]);
      end
   endtask

   task automatic test_fail_capture();
      do_reset();
      load_std(); go();
      store(104, 4097);
      checks++;
      if ({failed[0], busy[0], fail_adr[0], fail_data[0]} !== {1'b1, 1'b0, 32'd104, 32'd4097}) begin
         errors++; $display("FAIL stop_capture: got failed=%b busy=%b adr=%0d data=%0d want 1 0 104 4097",
                            failed[0], busy[0], fail_adr[0], fail_data[0]);
      end
      store(200, 7); store(100, 25);
      checks++;
      if ({fail_count[0], pass_count[0]} !== {4'd1, 4'd0}) begin
         errors++; $display("FAIL stop_frozen: got fail=%0d pass=%0d want 1 0", fail_count[0], pass_count[0]);
      end
      checks++;
      if ({fail_count[1], pass_count[1], busy[1], failed[1], fail_adr[1], fail_data[1]} !==
          {4'd2, 4'd1, 1'b1, 1'b1, 32'd104, 32'd4097}) begin
         errors++; $display("FAIL keep_going: got fail=%0d pass=%0d busy=%b adr=%0d data=%0d want 2 1 1 104 4097",
                            fail_count[1], pass_count[1], busy[1], fail_adr[1], fail_data[1]);
      end
   endtask

   task automatic test_duplicate();
      do_reset();
      load_std(); go();
      store(100, 25); store(100, 25);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pass_count[i], fail_count[i], failed[i]} !== {4'd1, 4'd1, 1'b1}) begin
            errors++; $display("FAIL duplicate[%0d]: got pass=%0d fail=%0d failed=%b want 1 1 1",
                               i, pass_count[i], fail_count[i], failed[i]);
         end
      end
      do_reset();
      load_std(); go();
      store(104, 4096); store(100, 25);
      checks++;
      if ({failed[0], pass_count[0], fail_adr[0]} !== {1'b1, 4'd0, 32'd104}) begin
         errors++; $display("FAIL order_violation: got failed=%b pass=%0d adr=%0d want 1 0 104",
                            failed[0], pass_count[0], fail_adr[0]);
      end
      checks++;
      if ({pass_count[1], fail_count[1], missing_count[1]} !== {4'd2, 4'd0, 4'd1}) begin
         errors++; $display("FAIL any_two_of_three: got pass=%0d fail=%0d miss=%0d want 2 0 1",
                            pass_count[1], fail_count[1], missing_count[1]);
      end
   endtask

   task automatic test_watchdog();
      int k;
      do_reset();
      go();
      k = 0;
      while (!timed_out[0] && k < 200) begin idle(); k++; end
      checks++;
      if (k != TMO || timed_out[1] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL watchdog_expiry: got cycles=%0d tmo1=%b busy=%b want %0d 1 0",
                            k, timed_out[1], busy[0], TMO);
      end
      do_reset();
      go();
      repeat (40) idle();
      store(97, 0);
      repeat (40) idle();
      checks++;
      if (timed_out[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL watchdog_cleared: got tmo=%b busy=%b want 0 1", timed_out[0], busy[0]);
      end
      repeat (10) idle();
      checks++;
      if (timed_out[0] !== 1'b1) begin
         errors++; $display("FAIL watchdog_after_clear: got tmo=%b want 1", timed_out[0]);
      end
   endtask

   task automatic test_full_table();
      do_reset();
      for (int j = 0; j < DEPTH - 1; j++) load(500 + 4 * j, j);
      checks++;
      if (load_full[0] !== 1'b0) begin
         errors++; $display("FAIL not_yet_full: got %b want 0", load_full[0]);
      end
      load(500 + 4 * (DEPTH - 1), DEPTH - 1);
      load(500 + 4 * DEPTH, DEPTH);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({load_full[i], missing_count[i]} !== {1'b1, 4'(DEPTH)}) begin
            errors++; $display("FAIL full_table[%0d]: got full=%b miss=%0d want 1 %0d",
                               i, load_full[i], missing_count[i], DEPTH);
         end
      end
      go();
      store(500 + 4 * DEPTH, DEPTH);
      checks++;
      if ({fail_count[1], pass_count[1]} !== {4'd1, 4'd0}) begin
         errors++; $display("FAIL dropped_entry: got fail=%0d pass=%0d want 1 0", fail_count[1], pass_count[1]);
      end
   endtask

   task automatic test_async_reset();
      logic [80:0] got;
      do_reset();
      load_std(); go();
      store(100, 25); store(104, 4096);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         got = {busy[i], done[i], timed_out[i], failed[i], load_full[i], pass_count[i],
                fail_count[i], missing_count[i], fail_adr[i], fail_data[i]};
         checks++;
         if (got !== '0) begin
            errors++; $display("FAIL async_reset[%0d]: got %h want 0", i, got);
         end
      end
      #2;
      reset = 1'b1;
      @(negedge clk);
      load_std(); go();
      store(100, 25); store(104, 4096); store(108, 4184); store(40, 30);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({done[i], pass_count[i], missing_count[i]} !== {1'b1, 4'd3, 4'd0}) begin
            errors++; $display("FAIL rerun[%0d]: got done=%b pass=%0d miss=%0d want 1 3 0",
                               i, done[i], pass_count[i], missing_count[i]);
         end
      end
   endtask

   task automatic test_random();
      int k, r, j;
      logic [80:0] got, exp;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         k = $urandom_range(0, DEPTH);
         for (int e = 0; e < k; e++) load(200 + 4 * $urandom_range(0, 7), $urandom_range(0, 3));
         go();
         for (int c = 0; c < 40; c++) begin
            r = $urandom_range(0, 99);
            if (r < 25 && mrp[0] < mn[0]) store(madr[mrp[0]], mdata[mrp[0]]);
            else if (r < 50 && mn[0] > 0) begin
               j = $urandom_range(0, mn[0] - 1);
               store(madr[j], mdata[j]);
            end
            else if (r < 62) store(96 + $urandom_range(0, 3), $urandom);
            else if (r < 65) store(40, 30);
            else if (r < 82) store(200 + 4 * $urandom_range(0, 7), $urandom_range(0, 3));
            else idle();
            for (int i = 0; i < 2; i++) begin
               got = {busy[i], done[i], timed_out[i], failed[i], load_full[i], pass_count[i],
                      fail_count[i], missing_count[i], fail_adr[i], fail_data[i]};
               exp = {ms[i] == MR, ms[i] == MD, ms[i] == MT, mfailed[i], mn[i] == DEPTH,
                      CW'(mpass[i]), CW'(mfail[i]), CW'(mn[i] - mpass[i]), mfadr[i], mfdata[i]};
               checks++;
               if (got !== exp) begin
                  errors++; $display("FAIL random[%0d] it=%0d cyc=%0d: got %h want %h", i, it, c, got, exp);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_ordered_pass();
      test_any_order();
      test_fail_capture();
      test_duplicate();
      test_watchdog();
      test_full_table();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

- Synthesizable self-checking monitor for the pipelined RISC-V core's data-memory write port.
- Holds a loadable table of expected (address, data) stores and compares every committed store against it, in ordered or any-order mode.
- Counts passes and failures, recognises an end-of-program marker store, and flags a stalled program via a watchdog.
- Sits beside `top`, tapping `MemWrite`/`DataAdr`/`WriteData`; usable in simulation benches and on FPGA with LEDs/UART reporting the counters.

## Interface
Parameters:
- ADDR_W, 32, width of DataAdr
- DATA_W, 32, width of WriteData
- DEPTH, 64, expected-table entries (≥1)
- ORDERED, 0, 1 = stores must match table in load order; 0 = any order
- STOP_ON_FAIL, 1, 1 = freeze on first failure; 0 = keep running, failure flag sticky
- DONE_ADR, 40 / DONE_DATA, 30, end-of-program marker store
- IGN_LO, 96 / IGN_HI, 99, inclusive scratch address window whose unmatched stores are ignored
- TIMEOUT, 100000, max cycles between stores in RUN; 0 disables
- CNT_W, $clog2(DEPTH+1), counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  append load_adr/load_data to table (LOAD state only)
- load_adr  in  ADDR_W  expected store address
- load_data  in  DATA_W  expected store data
- load_full  out  1  table holds DEPTH entries
- start  in  1  LOAD → RUN
- MemWrite  in  1  store strobe from core
- DataAdr  in  ADDR_W  store address
- WriteData  in  DATA_W  store data
- busy  out  1  state == RUN
- done  out  1  marker seen, terminal
- failed  out  1  sticky: at least one failure
- timed_out  out  1  watchdog expired, terminal
- pass_count  out  CNT_W  matched stores
- fail_count  out  CNT_W  failed stores, saturating
- missing_count  out  CNT_W  loaded entries − pass_count
- fail_adr / fail_data  out  ADDR_W / DATA_W  first failing store

## Operation
- States: LOAD (reset state), RUN, DONE, FAIL, TMO. DONE/FAIL/TMO are terminal; only reset leaves them.
- LOAD: each load_valid writes entry[n], n++. Ignored when n == DEPTH. MemWrite ignored. start moves to RUN, including with n == 0.
- RUN: each cycle with MemWrite=1 classifies the store, priority order:
  1. Match.
     - ORDERED=1: equals entry[rd_ptr], rd_ptr < n; rd_ptr++.
     - ORDERED=0: equals lowest-index un-hit entry; that entry's hit bit is set.
     - Result: pass_count++.
  2. Marker: DataAdr==DONE_ADR and WriteData==DONE_DATA → DONE.
  3. Ignore: IGN_LO ≤ DataAdr ≤ IGN_HI → no effect.
  4. Otherwise failure.
     - fail_count++ (saturating); failed=1.
     - fail_adr/fail_data captured on the first failure only.
     - Enter FAIL if STOP_ON_FAIL=1.
- A store equal to an already-hit entry (duplicate) with no un-hit match falls to rules 2–4.
- In ORDERED mode, an out-of-order store falls to rules 2–4; rd_ptr does not advance.
- load_valid and start are ignored outside LOAD.
- Watchdog: counter clears on MemWrite or on RUN entry, increments otherwise in RUN. Reaching TIMEOUT → TMO. Disabled when TIMEOUT=0.
- missing_count = n − pass_count, combinational.

## Timing
- All state, counters, flags and captures update on the rising clk edge after the sampled MemWrite cycle (1-cycle latency). missing_count follows pass_count combinationally.
- One store is classified per cycle; back-to-back stores are each classified.
- A marker store and a watchdog expiry in the same cycle: marker wins (MemWrite clears the watchdog).
- reset low, asynchronously:
  - State → LOAD; n, rd_ptr, hit bits, watchdog → 0.
  - All outputs 0, except load_full=0 and busy=0; fail_adr/fail_data → 0.
  - Reset mid-RUN discards the table.
- The table uses registers, not RAM: the any-order search must complete in one cycle.

## Test plan
- Ordered pass: load (100,25),(104,4096),(108,4184); start; issue those stores in order then (40,30) → pass_count=3, missing_count=0, done=1 one cycle after marker, failed=0.
- Any order plus ignore window: ORDERED=0, same table, stores (108,4184),(97,0xAA),(100,25),(104,4096),(40,30) → pass_count=3, fail_count=0, done=1.
- Failure capture: STOP_ON_FAIL=1, store (104,4097) → FAIL, failed=1, fail_adr=104, fail_data=4097, later stores ignored. Repeat with STOP_ON_FAIL=0 and two bad stores → fail_count=2, capture holds the first.
- Duplicate and order: ORDERED=1, store (104,4096) before (100,25) → failure. ORDERED=0, (100,25) twice → pass_count=1, fail_count=1.
- Watchdog and full table: TIMEOUT=50, start with no stores → timed_out=1 at cycle 50. DEPTH+1 loads → load_full=1, missing_count=DEPTH.
- Async reset mid-RUN after 2 passes → all outputs 0 without a clock edge; reload and rerun succeeds.
